// File: rtl/vrf_access_ctrl.sv
// vrf_access_ctrl: round-robin write-port arbiter and read-hazard guard in front of the latch-based VRF.
// Optional byte-merging read forwarding from in-flight writes is enabled by VRF_ACCESS_CTRL_FWD_EN.
module vrf_access_ctrl #(
    parameter int unsigned NrWrPorts   = 3,
    parameter int unsigned NrReadPorts = 3,
    parameter int unsigned NrWords     = 32,
    parameter int unsigned WordWidth   = 64,
    localparam int unsigned AddrW      = (NrWords > 1) ? $clog2(NrWords) : 1,
    localparam int unsigned BeW        = WordWidth / 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NrWrPorts-1:0]                   wr_req_i,
    input  logic [NrWrPorts-1:0][AddrW-1:0]        wr_addr_i,
    input  logic [NrWrPorts-1:0][WordWidth-1:0]    wr_data_i,
    input  logic [NrWrPorts-1:0][BeW-1:0]          wr_be_i,
    output logic [NrWrPorts-1:0]                   wr_gnt_o,
    input  logic [NrReadPorts-1:0]                 rd_req_i,
    input  logic [NrReadPorts-1:0][AddrW-1:0]      rd_addr_i,
    output logic [NrReadPorts-1:0]                 rd_gnt_o,
    output logic [NrReadPorts-1:0][WordWidth-1:0]  rd_data_o,
    output logic                                   vrf_we_o,
    output logic [AddrW-1:0]                       vrf_waddr_o,
    output logic [WordWidth-1:0]                   vrf_wdata_o,
    output logic [BeW-1:0]                         vrf_wbe_o,
    output logic [NrReadPorts-1:0][AddrW-1:0]      vrf_raddr_o,
    input  logic [NrReadPorts-1:0][WordWidth-1:0]  vrf_rdata_i,
    output logic [15:0]                            stall_cnt_o
);

    localparam int unsigned PtrW = (NrWrPorts > 1) ? $clog2(NrWrPorts) : 1;

    logic [PtrW-1:0]      rr_q;
    logic                 win_valid;
    logic [PtrW-1:0]      win_idx;

    logic                 s0_valid;
    logic [AddrW-1:0]     s0_addr;
    logic [WordWidth-1:0] s0_data;
    logic [BeW-1:0]       s0_be;

    logic                 s1_valid_q;
    logic [AddrW-1:0]     s1_addr_q;
`ifdef VRF_ACCESS_CTRL_FWD_EN
    logic [WordWidth-1:0] s1_data_q;
    logic [BeW-1:0]       s1_be_q;
`endif

    logic [NrReadPorts-1:0] hit_s0;
    logic [NrReadPorts-1:0] hit_s1;
    logic                   stall_event;
    logic [15:0]            stall_cnt_q;

    // Round-robin search starting at rr_q; reset masks every grant.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NrWrPorts; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NrWrPorts) idx = idx - NrWrPorts;
            if (!win_valid && wr_req_i[PtrW'(idx)]) begin
                win_valid = 1'b1;
                win_idx   = PtrW'(idx);
            end
        end
        win_valid = win_valid & rst_ni;
    end

    assign wr_gnt_o    = win_valid ? (NrWrPorts'(1) << win_idx) : '0;
    assign s0_valid    = win_valid;
    assign s0_addr     = wr_addr_i[win_idx];
    assign s0_data     = wr_data_i[win_idx];
    assign s0_be       = wr_be_i[win_idx];

    assign vrf_we_o    = s0_valid;
    assign vrf_waddr_o = s0_addr;
    assign vrf_wdata_o = s0_data;
    assign vrf_wbe_o   = s0_valid ? s0_be : '0;
    assign vrf_raddr_o = rd_addr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (win_valid) begin
            rr_q <= (win_idx == PtrW'(NrWrPorts - 1)) ? '0 : win_idx + PtrW'(1);
        end
    end

    // S1 mirrors the write the VRF is still sampling (visible from the next cycle on).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
`ifdef VRF_ACCESS_CTRL_FWD_EN
            s1_data_q  <= '0;
            s1_be_q    <= '0;
`endif
        end else begin
            s1_valid_q <= s0_valid;
            s1_addr_q  <= s0_addr;
`ifdef VRF_ACCESS_CTRL_FWD_EN
            s1_data_q  <= s0_data;
            s1_be_q    <= s0_be;
`endif
        end
    end

    always_comb begin
        hit_s0 = '0;
        hit_s1 = '0;
        for (int unsigned p = 0; p < NrReadPorts; p++) begin
            hit_s0[p] = s0_valid   && (rd_addr_i[p] == s0_addr);
            hit_s1[p] = s1_valid_q && (rd_addr_i[p] == s1_addr_q);
        end
    end

`ifdef VRF_ACCESS_CTRL_FWD_EN
    // Per-byte merge: the younger write (S0) wins over S1, which wins over the array.
    always_comb begin
        rd_gnt_o  = rd_req_i & {NrReadPorts{rst_ni}};
        rd_data_o = vrf_rdata_i;
        for (int unsigned p = 0; p < NrReadPorts; p++) begin
            for (int unsigned b = 0; b < BeW; b++) begin
                if (hit_s0[p] && s0_be[b]) begin
                    rd_data_o[p][b*8 +: 8] = s0_data[b*8 +: 8];
                end else if (hit_s1[p] && s1_be_q[b]) begin
                    rd_data_o[p][b*8 +: 8] = s1_data_q[b*8 +: 8];
                end
            end
        end
    end
`else
    // Any address match against an in-flight write blocks the read, byte enables ignored.
    always_comb begin
        rd_gnt_o  = rd_req_i & ~(hit_s0 | hit_s1) & {NrReadPorts{rst_ni}};
        rd_data_o = vrf_rdata_i;
    end
`endif

    assign stall_event = |(rd_req_i & ~rd_gnt_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Testbench for vrf_access_ctrl: directed scenarios then random traffic against a cycle-level
// reference of arbitration, hazard and VRF write-visibility rules; includes a small VRF array model.
module tb_vrf_access_ctrl;

    localparam int unsigned NW     = 3;
    localparam int unsigned NR     = 3;
    localparam int unsigned NWORDS = 32;
    localparam int unsigned WW     = 64;
    localparam int unsigned AW     = 5;
    localparam int unsigned BW     = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [NW-1:0]         wr_req_i;
    logic [NW-1:0][AW-1:0] wr_addr_i;
    logic [NW-1:0][WW-1:0] wr_data_i;
    logic [NW-1:0][BW-1:0] wr_be_i;
    logic [NW-1:0]         wr_gnt_o;
    logic [NR-1:0]         rd_req_i;
    logic [NR-1:0][AW-1:0] rd_addr_i;
    logic [NR-1:0]         rd_gnt_o;
    logic [NR-1:0][WW-1:0] rd_data_o;
    logic                  vrf_we_o;
    logic [AW-1:0]         vrf_waddr_o;
    logic [WW-1:0]         vrf_wdata_o;
    logic [BW-1:0]         vrf_wbe_o;
    logic [NR-1:0][AW-1:0] vrf_raddr_o;
    logic [NR-1:0][WW-1:0] vrf_rdata_i;
    logic [15:0]           stall_cnt_o;

    always #5 clk_i = ~clk_i;

    vrf_access_ctrl #(
        .NrWrPorts  (NW),
        .NrReadPorts(NR),
        .NrWords    (NWORDS),
        .WordWidth  (WW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_req_i   (wr_req_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .wr_be_i    (wr_be_i),
        .wr_gnt_o   (wr_gnt_o),
        .rd_req_i   (rd_req_i),
        .rd_addr_i  (rd_addr_i),
        .rd_gnt_o   (rd_gnt_o),
        .rd_data_o  (rd_data_o),
        .vrf_we_o   (vrf_we_o),
        .vrf_waddr_o(vrf_waddr_o),
        .vrf_wdata_o(vrf_wdata_o),
        .vrf_wbe_o  (vrf_wbe_o),
        .vrf_raddr_o(vrf_raddr_o),
        .vrf_rdata_i(vrf_rdata_i),
        .stall_cnt_o(stall_cnt_o)
    );

    // VRF stand-in: a write presented in cycle N lands in the array at the end of cycle N+1.
    logic [WW-1:0] mem [NWORDS];
    logic [WW-1:0] ref_mem [NWORDS];
    logic          preload;
    logic          pv;
    logic [AW-1:0] pa;
    logic [WW-1:0] pd;
    logic [BW-1:0] pb;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= 1'b0;
            pa <= '0;
            pd <= '0;
            pb <= '0;
        end else begin
            pv <= vrf_we_o;
            pa <= vrf_waddr_o;
            pd <= vrf_wdata_o;
            pb <= vrf_wbe_o;
        end
    end

    always @(posedge clk_i) begin
        if (preload) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= ref_mem[i];
        end else if (pv) begin
            for (int b = 0; b < BW; b++) if (pb[b]) mem[pa][b*8 +: 8] <= pd[b*8 +: 8];
        end
    end

    always_comb begin
        for (int p = 0; p < NR; p++) vrf_rdata_i[p] = mem[vrf_raddr_o[p]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: rr pointer, the two most recent accepted writes, stall count.
    int            ptr;
    int            exp_stall;
    logic          h1_v;
    logic [AW-1:0] h1_a;
    logic [WW-1:0] h1_d;
    logic [BW-1:0] h1_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_idle();
        wr_req_i = '0;
        rd_req_i = '0;
        for (int k = 0; k < NW; k++) begin
            wr_addr_i[k] = '0;
            wr_data_i[k] = '0;
            wr_be_i[k]   = '0;
        end
        for (int p = 0; p < NR; p++) rd_addr_i[p] = '0;
    endtask

    // Call once inputs have settled after the falling edge; checks, then advances one clock.
    task automatic run_cycle();
        int            win;
        logic          h0v;
        logic [AW-1:0] h0a;
        logic [WW-1:0] h0d;
        logic [BW-1:0] h0b;
        logic          egnt;
        logic          any_stall;
        logic          hit0;
        logic          hit1;
        logic [WW-1:0] ed;
        if (!rst_ni) begin
            exp_stall = 0;
            h1_v      = 1'b0;
        end
        win = -1;
        if (rst_ni) begin
            for (int i = 0; i < NW; i++) begin
                int k;
                k = (ptr + i) % NW;
                if (win < 0 && wr_req_i[k]) win = k;
            end
        end
        h0v = (win >= 0);
        h0a = h0v ? wr_addr_i[win] : '0;
        h0d = h0v ? wr_data_i[win] : '0;
        h0b = h0v ? wr_be_i[win]   : '0;
        chk("wr_gnt", 64'(wr_gnt_o), h0v ? (64'd1 << win) : 64'd0);
        chk("vrf_we", 64'(vrf_we_o), 64'(h0v));
        if (h0v) begin
            chk("vrf_waddr", 64'(vrf_waddr_o), 64'(h0a));
            chk("vrf_wdata", vrf_wdata_o, h0d);
            chk("vrf_wbe", 64'(vrf_wbe_o), 64'(h0b));
        end
        if (!rst_ni) chk("vrf_wbe_rst", 64'(vrf_wbe_o), 64'd0);
        any_stall = 1'b0;
        for (int p = 0; p < NR; p++) begin
            hit0 = h0v  && (rd_addr_i[p] == h0a);
            hit1 = h1_v && (rd_addr_i[p] == h1_a);
            ed   = ref_mem[rd_addr_i[p]];
`ifdef VRF_ACCESS_CTRL_FWD_EN
            egnt = rd_req_i[p] && rst_ni;
            for (int b = 0; b < BW; b++) begin
                if (hit0 && h0b[b])      ed[b*8 +: 8] = h0d[b*8 +: 8];
                else if (hit1 && h1_b[b]) ed[b*8 +: 8] = h1_d[b*8 +: 8];
            end
`else
            egnt = rd_req_i[p] && rst_ni && !hit0 && !hit1;
`endif
            chk($sformatf("rd_gnt[%0d]", p), 64'(rd_gnt_o[p]), 64'(egnt));
            if (egnt) chk($sformatf("rd_data[%0d]", p), rd_data_o[p], ed);
            chk($sformatf("vrf_raddr[%0d]", p), 64'(vrf_raddr_o[p]), 64'(rd_addr_i[p]));
            if (rst_ni && rd_req_i[p] && !egnt) any_stall = 1'b1;
        end
        chk("stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
        @(posedge clk_i);
        if (rst_ni) begin
            if (h1_v) begin
                for (int b = 0; b < BW; b++) if (h1_b[b]) ref_mem[h1_a][b*8 +: 8] = h1_d[b*8 +: 8];
            end
            h1_v = h0v;
            h1_a = h0a;
            h1_d = h0d;
            h1_b = h0b;
            if (h0v) ptr = (win + 1) % NW;
            if (any_stall && exp_stall < 65535) exp_stall++;
        end else begin
            ptr       = 0;
            h1_v      = 1'b0;
            exp_stall = 0;
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [NW-1:0] rr_seq [6];
        ptr       = 0;
        exp_stall = 0;
        h1_v      = 1'b0;
        h1_a      = '0;
        h1_d      = '0;
        h1_b      = '0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = {$urandom(), $urandom()};
        ref_mem[7] = 64'h1111_1111_1111_1111;
        rst_ni  = 1'b0;
        preload = 1'b1;
        set_idle();
        @(negedge clk_i);

        // Held in reset with every requester active: nothing may be granted.
        for (int c = 0; c < 2; c++) begin
            wr_req_i = '1;
            rd_req_i = '1;
            for (int k = 0; k < NW; k++) wr_be_i[k] = 8'hFF;
            #1;
            chk("rst_wr_gnt", 64'(wr_gnt_o), 64'd0);
            chk("rst_rd_gnt", 64'(rd_gnt_o), 64'd0);
            chk("rst_we", 64'(vrf_we_o), 64'd0);
            chk("rst_wbe", 64'(vrf_wbe_o), 64'd0);
            chk("rst_stall", 64'(stall_cnt_o), 64'd0);
            run_cycle();
        end
        rst_ni  = 1'b1;
        preload = 1'b0;

        // Round robin with all three requesters held high.
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int c = 0; c < 6; c++) begin
            set_idle();
            wr_req_i = '1;
            for (int k = 0; k < NW; k++) begin
                wr_addr_i[k] = AW'(10 + k);
                wr_data_i[k] = {$urandom(), $urandom()};
                wr_be_i[k]   = 8'hFF;
            end
            #1;
            chk("rr_seq", 64'(wr_gnt_o), 64'(rr_seq[c]));
            chk("rr_we", 64'(vrf_we_o), 64'd1);
            run_cycle();
        end
        set_idle();
        #1;
        chk("idle_we", 64'(vrf_we_o), 64'd0);
        run_cycle();
        set_idle();
        wr_req_i = '1;
        for (int k = 0; k < NW; k++) wr_addr_i[k] = AW'(10 + k);
        #1;
        chk("rr_ptr0", 64'(wr_gnt_o), 64'd1);
        run_cycle();

        // Write 5 then read 5 for three cycles.
        for (int c = 0; c < 3; c++) begin
            set_idle();
            if (c == 0) begin
                wr_req_i     = 3'b001;
                wr_addr_i[0] = AW'(5);
                wr_data_i[0] = 64'hAAAA_AAAA_AAAA_AAAA;
                wr_be_i[0]   = 8'hFF;
            end
            rd_req_i     = 3'b001;
            rd_addr_i[0] = AW'(5);
            #1;
`ifdef VRF_ACCESS_CTRL_FWD_EN
            chk("w5_gnt", 64'(rd_gnt_o[0]), 64'd1);
            chk("w5_data", rd_data_o[0], 64'hAAAA_AAAA_AAAA_AAAA);
`else
            chk("w5_gnt", 64'(rd_gnt_o[0]), (c == 2) ? 64'd1 : 64'd0);
            if (c == 2) chk("w5_data", rd_data_o[0], 64'hAAAA_AAAA_AAAA_AAAA);
`endif
            run_cycle();
        end
        set_idle();
        #1;
`ifdef VRF_ACCESS_CTRL_FWD_EN
        chk("w5_stall", 64'(stall_cnt_o), 64'd0);
`else
        chk("w5_stall", 64'(stall_cnt_o), 64'd2);
`endif
        run_cycle();

        // Partial write of byte 0 to addr 7, read it back in the next two cycles.
        set_idle();
        wr_req_i     = 3'b010;
        wr_addr_i[1] = AW'(7);
        wr_data_i[1] = 64'hDEAD_BEEF_CAFE_0022;
        wr_be_i[1]   = 8'h01;
        #1;
        run_cycle();
        for (int c = 0; c < 2; c++) begin
            set_idle();
            rd_req_i     = 3'b010;
            rd_addr_i[1] = AW'(7);
            #1;
`ifdef VRF_ACCESS_CTRL_FWD_EN
            chk("w7_data", rd_data_o[1], 64'h1111_1111_1111_1122);
`else
            chk("w7_gnt", 64'(rd_gnt_o[1]), (c == 1) ? 64'd1 : 64'd0);
            if (c == 1) chk("w7_data", rd_data_o[1], 64'h1111_1111_1111_1122);
`endif
            run_cycle();
        end

        // Back-to-back writes to addr 3; younger partial write overlays the older one.
        set_idle();
        wr_req_i     = 3'b100;
        wr_addr_i[2] = AW'(3);
        wr_data_i[2] = 64'hA0A1_A2A3_A4A5_A6A7;
        wr_be_i[2]   = 8'hFF;
        #1;
        run_cycle();
        set_idle();
        wr_req_i     = 3'b001;
        wr_addr_i[0] = AW'(3);
        wr_data_i[0] = 64'hB0B1_B2B3_B4B5_B6B7;
        wr_be_i[0]   = 8'h0F;
        rd_req_i     = 3'b100;
        rd_addr_i[2] = AW'(3);
        #1;
`ifdef VRF_ACCESS_CTRL_FWD_EN
        chk("w3_merge", rd_data_o[2], 64'hA0A1_A2A3_B4B5_B6B7);
        chk("w3_stall", 64'(stall_cnt_o), 64'd0);
`else
        chk("w3_gnt", 64'(rd_gnt_o[2]), 64'd0);
`endif
        run_cycle();

        // Read of an unrelated address is never held up.
        for (int c = 0; c < 2; c++) begin
            set_idle();
            wr_req_i     = 3'b011;
            wr_addr_i[0] = AW'(4);
            wr_addr_i[1] = AW'(4);
            wr_be_i[0]   = 8'hFF;
            wr_be_i[1]   = 8'hFF;
            wr_data_i[0] = {$urandom(), $urandom()};
            wr_data_i[1] = {$urandom(), $urandom()};
            rd_req_i     = 3'b001;
            rd_addr_i[0] = AW'(9);
            #1;
            chk("r9_gnt", 64'(rd_gnt_o[0]), 64'd1);
            chk("r9_raddr", 64'(vrf_raddr_o[0]), 64'd9);
            run_cycle();
        end

        // Reset in the cycle after a write.
        set_idle();
        wr_req_i     = 3'b010;
        wr_addr_i[1] = AW'(6);
        wr_data_i[1] = 64'h6666_6666_6666_6666;
        wr_be_i[1]   = 8'hFF;
        #1;
        run_cycle();
        set_idle();
        rst_ni   = 1'b0;
        wr_req_i = '1;
        rd_req_i = '1;
        for (int p = 0; p < NR; p++) rd_addr_i[p] = AW'(6);
        #1;
        chk("mrst_wr_gnt", 64'(wr_gnt_o), 64'd0);
        chk("mrst_rd_gnt", 64'(rd_gnt_o), 64'd0);
        chk("mrst_stall", 64'(stall_cnt_o), 64'd0);
        run_cycle();
        rst_ni = 1'b1;
        set_idle();
        wr_req_i = '1;
        #1;
        chk("mrst_ptr0", 64'(wr_gnt_o), 64'd1);
        run_cycle();

        // Random traffic with narrow address ranges to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            set_idle();
            rst_ni   = ($urandom_range(0, 63) != 0);
            wr_req_i = NW'($urandom());
            rd_req_i = NR'($urandom());
            for (int k = 0; k < NW; k++) begin
                wr_addr_i[k] = AW'($urandom_range(0, 5));
                wr_data_i[k] = {$urandom(), $urandom()};
                wr_be_i[k]   = BW'($urandom());
            end
            for (int p = 0; p < NR; p++) rd_addr_i[p] = AW'($urandom_range(0, 6));
            #1;
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
